// File: rtl/ddr_wr_feeder.sv
// Write-path feeder for a DDR PHY: buffers 2-beat words and streams them as whole
// bursts into the DQ/DQS output DDR cells, with preamble and postamble cycles.
module ddr_wr_feeder #(
  parameter int DQ_W       = 8,
  parameter int BURST_SCLK = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              SCLK,
  input  logic              RSTB,
  input  logic              WR_VALID,
  input  logic [2*DQ_W-1:0] WR_DATA,
  output logic              WR_READY,
  output logic [DQ_W-1:0]   DQ_D0,
  output logic [DQ_W-1:0]   DQ_D1,
  output logic              DQS_D0,
  output logic              DQS_D1,
  output logic              DQ_OE,
  output logic              DQS_OE,
  output logic              BUSY,
  output logic              BURST_DONE,
  output logic [7:0]        BURST_CNT
);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BEAT_W = (BURST_SCLK > 1) ? $clog2(BURST_SCLK) : 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  BURST_C   = CNT_W'(BURST_SCLK);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_SCLK - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, PRE, DATA, POST} state_t;

  state_t             state_reg, state_next;
  logic [BEAT_W-1:0]  beat_reg, beat_next;
  logic [2*DQ_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next, count_after_pop;
  logic               push, pop, last_beat, bypass;
  logic [2*DQ_W-1:0]  rd_word;

  logic [DQ_W-1:0]    dq_d0_reg, dq_d1_reg;
  logic               dqs_d0_reg, dq_oe_reg, dqs_oe_reg, busy_reg, burst_done_reg;
  logic [7:0]         burst_cnt_reg;

  // No bypass: a full FIFO refuses a word even in a cycle that pops.
  assign WR_READY  = !RSTB && (count_reg < DEPTH_C);
  assign push      = WR_VALID && WR_READY;
  assign pop       = (state_reg == DATA);
  assign last_beat = (state_reg == DATA) && (beat_reg == LAST_BEAT);

  always_comb begin
    count_after_pop = count_reg - CNT_W'(pop);
    count_next      = count_after_pop + CNT_W'(push);
    rd_ptr_next     = rd_ptr_reg;
    if (pop)
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
  end

  // A continuation burst can need the word being written this very edge
  // (only possible with one-cycle bursts); forward it from the input.
  assign bypass  = push && (count_after_pop == '0);
  assign rd_word = bypass ? WR_DATA : mem[rd_ptr_next];

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    case (state_reg)
      IDLE: if (count_reg >= BURST_C) state_next = PRE;
      PRE: begin
        state_next = DATA;
        beat_next  = '0;
      end
      DATA: begin
        if (beat_reg == LAST_BEAT) begin
          beat_next  = '0;
          state_next = (count_next >= BURST_C) ? DATA : POST;
        end else begin
          beat_next = beat_reg + 1'b1;
        end
      end
      POST:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (push) mem[wr_ptr_reg] <= WR_DATA;
  end

  always_ff @(posedge SCLK) begin
    if (RSTB) begin
      state_reg  <= IDLE;
      beat_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      beat_reg   <= beat_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (push) wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge SCLK) begin
    if (RSTB) begin
      dq_d0_reg      <= '0;
      dq_d1_reg      <= '0;
      dqs_d0_reg     <= 1'b0;
      dq_oe_reg      <= 1'b0;
      dqs_oe_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      burst_done_reg <= 1'b0;
      burst_cnt_reg  <= 8'd0;
    end else begin
      dqs_d0_reg     <= (state_next == DATA);
      dq_oe_reg      <= (state_next == DATA);
      dqs_oe_reg     <= (state_next != IDLE);
      busy_reg       <= (state_next != IDLE);
      burst_done_reg <= last_beat;
      if (last_beat) burst_cnt_reg <= burst_cnt_reg + 8'd1;
      if (state_next == DATA) begin
        dq_d0_reg <= rd_word[DQ_W-1:0];
        dq_d1_reg <= rd_word[2*DQ_W-1:DQ_W];
      end else begin
        dq_d0_reg <= '0;
        dq_d1_reg <= '0;
      end
    end
  end

  assign DQ_D0      = dq_d0_reg;
  assign DQ_D1      = dq_d1_reg;
  assign DQS_D0     = dqs_d0_reg;
  assign DQS_D1     = 1'b0;
  assign DQ_OE      = dq_oe_reg;
  assign DQS_OE     = dqs_oe_reg;
  assign BUSY       = busy_reg;
  assign BURST_DONE = burst_done_reg;
  assign BURST_CNT  = burst_cnt_reg;

endmodule

// File: tb/tb_ddr_wr_feeder.sv
// Scoreboard bench for ddr_wr_feeder: accepted words queue up as expected DQ beats,
// and a negedge monitor checks every cycle against burst-level framing rules.
module tb_ddr_wr_feeder;
  localparam int DQ_W  = 8;
  localparam int B     = 2;
  localparam int DEPTH = 4;
  localparam int K_IDLE = 0, K_PRE = 1, K_DATA = 2, K_POST = 3;

  logic              SCLK = 1'b0;
  logic              RSTB = 1'b1;
  logic              WR_VALID = 1'b0;
  logic [2*DQ_W-1:0] WR_DATA = '0;
  logic              WR_READY;
  logic [DQ_W-1:0]   DQ_D0, DQ_D1;
  logic              DQS_D0, DQS_D1, DQ_OE, DQS_OE, BUSY, BURST_DONE;
  logic [7:0]        BURST_CNT;

  ddr_wr_feeder #(.DQ_W(DQ_W), .BURST_SCLK(B), .FIFO_DEPTH(DEPTH)) dut (
    .SCLK(SCLK), .RSTB(RSTB), .WR_VALID(WR_VALID), .WR_DATA(WR_DATA),
    .WR_READY(WR_READY), .DQ_D0(DQ_D0), .DQ_D1(DQ_D1), .DQS_D0(DQS_D0),
    .DQS_D1(DQS_D1), .DQ_OE(DQ_OE), .DQS_OE(DQS_OE), .BUSY(BUSY),
    .BURST_DONE(BURST_DONE), .BURST_CNT(BURST_CNT)
  );

  always #5 SCLK = ~SCLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: words in flight are a queue; the cycle kind the bench expects next
  // follows from the burst rules (whole bursts only, preamble, postamble, chaining).
  logic [2*DQ_W-1:0] exp_q[$];
  int          exp_kind = K_IDLE;
  int          exp_beat = 0;
  int          exp_bcnt = 0;
  bit          done_next = 1'b0;
  int          cnt0, nk, nb;
  bit          nd;
  logic [4:0]  exp_ctl;
  logic [2*DQ_W-1:0] w;

  always @(negedge SCLK) begin
    cnt0 = exp_q.size();
    case (exp_kind)
      K_IDLE:       exp_ctl = 5'b00000;
      K_PRE, K_POST: exp_ctl = 5'b10100;
      default:      exp_ctl = 5'b11110;
    endcase
    chk("ctl{busy,dq_oe,dqs_oe,dqs_d0,dqs_d1}", {BUSY, DQ_OE, DQS_OE, DQS_D0, DQS_D1}, exp_ctl);
    chk("burst_done", BURST_DONE, done_next);
    chk("burst_cnt", BURST_CNT, 32'(exp_bcnt));
    chk("wr_ready", WR_READY, (RSTB == 1'b0 && cnt0 < DEPTH) ? 1 : 0);
    if (exp_kind == K_DATA) begin
      if (cnt0 == 0) begin
        n_vec++; n_err++;
        $display("FAIL underrun: got DQ %0h with no word expected at %0t", {DQ_D1, DQ_D0}, $time);
      end else begin
        w = exp_q.pop_front();
        chk("dq_d0", DQ_D0, w[DQ_W-1:0]);
        chk("dq_d1", DQ_D1, w[2*DQ_W-1:DQ_W]);
      end
    end else begin
      chk("dq_quiet", {DQ_D1, DQ_D0}, 0);
    end
    if (WR_VALID && WR_READY && !RSTB) exp_q.push_back(WR_DATA);

    nd = 1'b0;
    nb = 0;
    case (exp_kind)
      K_IDLE: nk = (cnt0 >= B) ? K_PRE : K_IDLE;
      K_PRE:  nk = K_DATA;
      K_DATA: begin
        if (exp_beat < B - 1) begin
          nk = K_DATA;
          nb = exp_beat + 1;
        end else begin
          nd = 1'b1;
          nk = (exp_q.size() >= B) ? K_DATA : K_POST;
        end
      end
      default: nk = K_IDLE;
    endcase
    if (nd) exp_bcnt = (exp_bcnt + 1) % 256;
    if (RSTB) begin
      exp_q.delete();
      nk = K_IDLE; nb = 0; nd = 1'b0; exp_bcnt = 0;
    end
    exp_kind  = nk;
    exp_beat  = nb;
    done_next = nd;
  end

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  task automatic push(input logic [2*DQ_W-1:0] d);
    int waited;
    waited = 0;
    WR_VALID = 1'b1;
    WR_DATA  = d;
    @(negedge SCLK);
    while (!WR_READY && waited < 50) begin
      @(negedge SCLK);
      waited++;
    end
    chk("push_accepted", WR_READY, 1);
    @(posedge SCLK);
    #1;
    WR_VALID = 1'b0;
  endtask

  initial begin
    int guard;
    // reset held two edges with a word offered: it must be ignored
    RSTB = 1'b1; WR_VALID = 1'b1; WR_DATA = 16'hFFFF;
    tick(); tick();
    RSTB = 1'b0; WR_VALID = 1'b0;
    tick();
    chk("ready_after_reset", WR_READY, 1);

    push(16'hA55A); push(16'h3CC3);
    repeat (6) tick();
    chk("single_bcnt", BURST_CNT, 1);

    push(16'h1234);
    repeat (4) tick();
    chk("partial_idle", BUSY, 0);
    push(16'h5678);
    repeat (6) tick();

    push(16'h0101); push(16'h0202); push(16'h0303); push(16'h0404);
    repeat (8) tick();
    chk("b2b_bcnt", BURST_CNT, 4);

    for (int i = 0; i < 5; i++) push(16'hB000 + 16'(i));
    repeat (10) tick();
    chk("bp_bcnt", BURST_CNT, 6);

    // one word is left over; a second starts a burst, reset lands on its first DATA cycle
    push(16'hC0DE);
    guard = 0;
    @(negedge SCLK);
    while (!(BUSY && !DQ_OE) && guard < 20) begin
      @(negedge SCLK);
      guard++;
    end
    chk("reached_pre", {BUSY, DQ_OE}, 2'b10);
    @(posedge SCLK); #1;
    RSTB = 1'b1;
    tick();
    RSTB = 1'b0;
    chk("rst_mid_oe", {DQ_OE, DQS_OE}, 0);
    chk("rst_mid_bcnt", BURST_CNT, 0);
    repeat (4) tick();

    for (int i = 0; i < 400; i++) begin
      RSTB     = ($urandom_range(0, 99) == 0);
      WR_VALID = ($urandom_range(0, 99) < 55);
      WR_DATA  = 16'($urandom);
      tick();
    end
    RSTB = 1'b0; WR_VALID = 1'b0;
    repeat (12) tick();
    chk("final_idle", BUSY, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
